stopwatch_bcd: RTL
==================

STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 4, meaning the number of cascaded BCD digits.
REQ-002 SHALL provide port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port tick  input  1  single-cycle count enable, driven by upstream divider terminal count (tc).
REQ-005 SHALL provide port start_stop  input  1  single-cycle pulse; toggles run/pause.
REQ-006 SHALL provide port clear  input  1  single-cycle pulse; returns to zero/idle.
REQ-007 SHALL provide port lap  input  1  single-cycle pulse; display hold toggle (present only with LAP_HOLD_EN).
REQ-008 SHALL provide port bcd  output  4*NUM_DIGITS  displayed count, digit 0 in bits [3:0], least significant.
REQ-009 SHALL provide port running  output  1  high while in RUN.
REQ-010 SHALL provide port ovf  output  1  one-cycle pulse on wrap-around.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, PAUSE; all outputs registered.
REQ-012 IDLE: count held at zero; start_stop -> RUN.
REQ-013 RUN: each clock edge with tick=1 increments count by one; start_stop -> PAUSE.
REQ-014 PAUSE: count held; tick ignored; start_stop -> RUN.
REQ-015 clear in any state -> IDLE, count zero, next edge; clear has priority over start_stop, tick, lap.
REQ-016 Increment latency: bcd reflects new value on the same edge that samples tick=1 (one-cycle registered update).
REQ-017 Each digit SHALL stay in 0-9; digit i increments only when tick=1 and all lower digits equal 9; digits equal to 9 under carry reset to 0.
REQ-018 Wrap-around: all digits 9 plus tick in RUN -> all digits 0 and ovf=1 for exactly that one following cycle; state remains RUN.
REQ-019 Simultaneous tick and start_stop in RUN: tick counted, then PAUSE.
REQ-020 Simultaneous tick and start_stop in IDLE or PAUSE: tick not counted, then RUN.
REQ-021 running SHALL equal 1 exactly when state is RUN.
REQ-022 Non-pulse inputs (held high several cycles) SHALL act once per high cycle; no internal edge detection.

Reset
REQ-023 rst low SHALL asynchronously force state IDLE, count zero, bcd zero, running 0, ovf 0, hold flag 0.
REQ-024 rst deassertion mid-operation SHALL resume from IDLE; no count retained.

Configuration
REQ-025 Macro LAP_HOLD_EN defined: lap pulse in RUN or PAUSE toggles a hold flag; while set, bcd shows snapshot captured at the lap edge while internal count keeps advancing; second lap releases hold and bcd shows live count next edge; clear or reset clears the hold.
REQ-026 Macro LAP_HOLD_EN undefined: lap port and hold logic absent; bcd always equals live count.
REQ-027 lap in IDLE SHALL be ignored.

Verification
REQ-028 rst=0 then 1, tick every 10 cycles, no start_stop -> bcd stays 0000, running 0.
REQ-029 start_stop, then 25 ticks -> bcd 0025, running 1; start_stop, 5 more ticks -> bcd 0025, running 0.
REQ-030 Preload by counting to 9998, two ticks -> 9999 then 0000, ovf high exactly one cycle, running 1.
REQ-031 RUN at 0007, clear and start_stop and tick same cycle -> bcd 0000, IDLE, running 0.
REQ-032 LAP_HOLD_EN: RUN at 0012, lap, 8 ticks -> bcd 0012; lap -> bcd 0020 next cycle.
REQ-033 RUN at 0040, rst low for 3 cycles mid-count -> bcd 0000 immediately, IDLE after release.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// Cascaded BCD stopwatch with IDLE/RUN/PAUSE control and registered outputs.
// Optional lap display hold is enabled by defining LAP_HOLD_EN.
module stopwatch_bcd #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    start_stop,
  input  logic                    clear,
`ifdef LAP_HOLD_EN
  input  logic                    lap,
`endif
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    running,
  output logic                    ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t                       r_state, w_state_nxt;
  logic [NUM_DIGITS-1:0][3:0]   r_cnt, w_cnt_inc, w_cnt_nxt;
  logic [NUM_DIGITS-1:0][3:0]   r_bcd, w_bcd_nxt;
  logic [NUM_DIGITS:0]          w_carry;
  logic                         r_running, r_ovf;
  logic                         w_run_nxt, w_ovf_nxt, w_count_en;

  // Ripple carry: a digit advances only when every lower digit is 9.
  assign w_carry[0] = 1'b1;
  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      assign w_carry[g+1]  = w_carry[g] & (r_cnt[g] == 4'd9);
      assign w_cnt_inc[g]  = !w_carry[g]        ? r_cnt[g] :
                             (r_cnt[g] == 4'd9) ? 4'd0     : r_cnt[g] + 4'd1;
    end
  endgenerate

  assign w_count_en = !clear && (r_state == S_RUN) && tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start_stop) w_state_nxt = S_RUN;
        S_RUN:   if (start_stop) w_state_nxt = S_PAUSE;
        S_PAUSE: if (start_stop) w_state_nxt = S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef LAP_HOLD_EN
  logic                       r_hold, w_hold_nxt, w_lap_en;
  logic [NUM_DIGITS-1:0][3:0] r_snap, w_snap_nxt;
`endif

  always_comb begin
    w_cnt_nxt = clear ? '0 : (w_count_en ? w_cnt_inc : r_cnt);
    w_ovf_nxt = w_count_en & w_carry[NUM_DIGITS];
    w_run_nxt = (w_state_nxt == S_RUN);
`ifdef LAP_HOLD_EN
    // Snapshot is the value the display would have shown on the lap edge.
    w_lap_en   = !clear && lap && (r_state != S_IDLE);
    w_hold_nxt = clear ? 1'b0 : (w_lap_en ? ~r_hold : r_hold);
    w_snap_nxt = (w_lap_en && !r_hold) ? w_cnt_nxt : r_snap;
    w_bcd_nxt  = w_hold_nxt ? w_snap_nxt : w_cnt_nxt;
`else
    w_bcd_nxt  = w_cnt_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_running <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_bcd     <= w_bcd_nxt;
      r_running <= w_run_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

`ifdef LAP_HOLD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= 1'b0;
      r_snap <= '0;
    end else begin
      r_hold <= w_hold_nxt;
      r_snap <= w_snap_nxt;
    end
  end
`endif

  assign bcd     = r_bcd;
  assign running = r_running;
  assign ovf     = r_ovf;

endmodule
